kanagawa_fifo_serializer: RTL and testbench
===========================================

// Module: kanagawa_fifo_serializer
//
// PURPOSE
//   Downstream consumer stage for a FIFO-style read port (empty/rdreq/q), such as a
//   one-entry register FIFO. Pops one wide word of WIDTH*RATIO bits and emits it as
//   RATIO narrow beats on a valid/ready output channel, with a last-beat marker.
//   Sits between a wide pipeline FIFO and a narrow egress/stream interface.
//   Back-to-back words stream with no idle cycle between them.
//
// PARAMETERS
//   WIDTH      32   narrow beat width in bits; wide word is WIDTH*RATIO bits
//   RATIO      4    beats per wide word; >=1 (elaboration error if 0)
//   LSB_FIRST  1    1: beat0 = word[WIDTH-1:0]; 0: beat0 = most significant slice
//
// PORTS
//   clock      in   1              rising-edge clock
//   rst        in   1              asynchronous reset, active-high
//   in_empty   in   1              upstream FIFO empty; in_q valid when 0
//   in_q       in   WIDTH*RATIO    upstream head word
//   in_rdreq   out  1              pop upstream head this cycle (combinational)
//   out_valid  out  1              out_data holds a valid beat
//   out_data   out  WIDTH          current beat
//   out_last   out  1              current beat is beat RATIO-1 of its word
//   out_ready  in   1              downstream accepts the beat when out_valid=1
//   busy       out  1              a word is held (equals out_valid)
//
// BEHAVIOUR
//   - State: hold_ff (WIDTH*RATIO), beat_ff ($clog2(RATIO) bits, min 1), busy_ff.
//   - Reset (async assert, sync release): busy_ff=0, beat_ff=0, so out_valid=0,
//     out_last=0, in_rdreq=0. hold_ff is not reset; out_data is don't-care while
//     out_valid=0.
//   - Beat fire: fire = out_valid & out_ready. last_fire = fire & (beat_ff==RATIO-1).
//   - Pop: in_rdreq = !in_empty & (!busy_ff | last_fire). in_rdreq never asserts
//     when in_empty=1 and never asserts during rst.
//   - On in_rdreq: hold_ff <= in_q (captured in the pop cycle, because the upstream
//     q may change afterwards), beat_ff <= 0, busy_ff <= 1.
//   - On a non-last fire: beat_ff <= beat_ff+1; hold_ff is unchanged.
//   - On last_fire without a pop: busy_ff <= 0, beat_ff <= 0.
//   - out_data = slice beat_ff of hold_ff (order set by LSB_FIRST), from a registered
//     mux select. out_valid = busy_ff. out_last = busy_ff & (beat_ff==RATIO-1).
//   - Latency: in_empty falls at cycle t -> in_rdreq=1 at t -> out_valid=1 with
//     beat0 at t+1.
//   - Throughput: one beat per cycle while out_ready=1. A word that is waiting when
//     last_fire occurs produces its beat0 on the next cycle, with no bubble.
//   - Backpressure: while out_valid & !out_ready, out_data, out_last and beat_ff
//     hold stable, and no pop occurs.
//   - RATIO==1: every beat is last. Degenerates to a one-register valid/ready stage.
//   - Reset mid-word: the partial word is discarded and the upstream is not re-popped.
//   - Assertions (under ifndef NO_DYNAMIC_ASSERTS):
//       in_rdreq -> !in_empty
//       out_valid & !out_ready |=> $stable(out_data) & out_valid
//
// TESTING
//   1 Reset: rst=1 with in_empty=0 -> in_rdreq=0, out_valid=0.
//     After release -> pop on first cycle, out_valid on the next.
//   2 Single word: RATIO=4, WIDTH=8, in_q=32'hDDCCBBAA, out_ready=1 -> beats AA,BB,CC,DD
//     on 4 consecutive cycles, out_last only on DD, then out_valid=0.
//   3 Streaming: two words always available, out_ready=1 -> 8 beats with no gap, and
//     in_rdreq pulses exactly on the cycles of beat DD of word 1 and at start.
//   4 Backpressure: out_ready=0 for 3 cycles at beat1 -> out_data=BB held stable,
//     in_rdreq=0 throughout. Resume -> CC, DD follow.
//   5 LSB_FIRST=0, same word -> beats DD,CC,BB,AA. RATIO=1 -> one beat per word,
//     out_last always 1.
//   6 Reset asserted at beat2 -> out_valid drops asynchronously, and after release
//     the next popped word starts at beat0. Random valid/ready scoreboard checks
//     ordering and count.

Source files
------------

// File: rtl/kanagawa_fifo_serializer.sv
// Pops one wide word from a FIFO read port and emits it as RATIO narrow beats
// on a valid/ready channel, with a last-beat marker.
module kanagawa_fifo_serializer #(
  parameter int WIDTH     = 32,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_empty,
  input  logic [WIDTH*RATIO-1:0] in_q,
  output logic                   in_rdreq,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [BW-1:0] SEL_FIRST = (LSB_FIRST != 0) ? '0 : LAST_BEAT;

  generate
    if (RATIO < 1) begin : g_bad_ratio
      $error("kanagawa_fifo_serializer: RATIO must be >= 1");
    end
  endgenerate

  logic [RATIO-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [BW-1:0]               sel_q, sel_d;
  logic                        busy_q, busy_d;
  logic                        fire, last_fire;

  always_comb begin
    fire      = busy_q & out_ready;
    last_fire = fire & (beat_q == LAST_BEAT);
    // rst gating keeps the pop off while the async reset is held
    in_rdreq  = ~rst & ~in_empty & (~busy_q | last_fire);

    hold_d = hold_q;
    beat_d = beat_q;
    sel_d  = sel_q;
    busy_d = busy_q;
    if (in_rdreq) begin
      hold_d = in_q;
      beat_d = '0;
      sel_d  = SEL_FIRST;
      busy_d = 1'b1;
    end else if (last_fire) begin
      beat_d = '0;
      sel_d  = SEL_FIRST;
      busy_d = 1'b0;
    end else if (fire) begin
      beat_d = beat_q + BW'(1);
      // slice select is kept in its own register so the output mux needs no adder
      sel_d  = (LSB_FIRST != 0) ? sel_q + BW'(1) : sel_q - BW'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      sel_q  <= SEL_FIRST;
      busy_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
    end
  end

  // data register is qualified by busy_q, so it needs no reset
  always_ff @(posedge clock) begin
    hold_q <= hold_d;
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel_q == BW'(i)) out_data = hold_q[i];
    end
  end

  assign out_valid = busy_q;
  assign out_last  = busy_q & (beat_q == LAST_BEAT);
  assign busy      = busy_q;

`ifndef NO_DYNAMIC_ASSERTS
  a_pop_not_empty: assert property (@(posedge clock) disable iff (rst)
    in_rdreq |-> !in_empty);
  a_hold_stall: assert property (@(posedge clock) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && out_valid));
`endif

endmodule

// File: tb/tb_kanagawa_fifo_serializer.sv
// Directed and scoreboarded checks of the FIFO-to-beat serializer in LSB-first,
// MSB-first and RATIO=1 configurations.
module tb_kanagawa_fifo_serializer;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        in_empty = 1'b1;
  logic [31:0] in_q = '0;
  logic        out_ready = 1'b1;

  logic        a_rdreq, a_valid, a_last, a_busy;
  logic [7:0]  a_data;
  logic        b_rdreq, b_valid, b_last, b_busy;
  logic [7:0]  b_data;

  logic        c_empty = 1'b1;
  logic [7:0]  c_q = '0;
  logic        c_ready = 1'b1;
  logic        c_rdreq, c_valid, c_last, c_busy;
  logic [7:0]  c_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  kanagawa_fifo_serializer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1)) dut_a (
    .clock(clock), .rst(rst), .in_empty(in_empty), .in_q(in_q), .in_rdreq(a_rdreq),
    .out_valid(a_valid), .out_data(a_data), .out_last(a_last), .out_ready(out_ready),
    .busy(a_busy));

  kanagawa_fifo_serializer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(0)) dut_b (
    .clock(clock), .rst(rst), .in_empty(in_empty), .in_q(in_q), .in_rdreq(b_rdreq),
    .out_valid(b_valid), .out_data(b_data), .out_last(b_last), .out_ready(out_ready),
    .busy(b_busy));

  kanagawa_fifo_serializer #(.WIDTH(8), .RATIO(1), .LSB_FIRST(1)) dut_c (
    .clock(clock), .rst(rst), .in_empty(c_empty), .in_q(c_q), .in_rdreq(c_rdreq),
    .out_valid(c_valid), .out_data(c_data), .out_last(c_last), .out_ready(c_ready),
    .busy(c_busy));

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drain();
    in_empty = 1'b1; out_ready = 1'b1; c_empty = 1'b1; c_ready = 1'b1;
    for (int i = 0; i < 12 && (a_valid || c_valid); i++) step();
    #1;
    n_cmp++;
    if (a_valid !== 1'b0 || c_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain: a_valid=%b c_valid=%b required 0", a_valid, c_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_empty = 1'b0; in_q = 32'h44332211; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    n_cmp++; if (a_rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_rdreq: got %b required 0", a_rdreq); end
    n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", a_valid); end
    n_cmp++; if (a_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b required 0", a_last); end
    @(posedge clock); #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (a_rdreq !== 1'b1) begin n_bad++; $display("FAIL release_pop: got %b required 1", a_rdreq); end
    step(); in_empty = 1'b1; #1;
    n_cmp++; if (a_valid !== 1'b1 || a_data !== 8'h11) begin
      n_bad++; $display("FAIL release_beat0: valid=%b data=%h required 1/11", a_valid, a_data); end
    repeat (4) step();
    #1;
    n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL release_idle: got %b required 0", a_valid); end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [7:0]  ea [4];
    logic [7:0]  eb [4];
    w = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin ea[i] = w[8*i +: 8]; eb[i] = w[8*(3-i) +: 8]; end
    step(); in_q = w; in_empty = 1'b0; out_ready = 1'b1; #1;
    n_cmp++; if (a_rdreq !== 1'b1 || b_rdreq !== 1'b1 || a_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_pop: rdreq=%b/%b valid=%b required 1/1/0", a_rdreq, b_rdreq, a_valid); end
    for (int i = 0; i < 4; i++) begin
      step(); in_empty = 1'b1; #1;
      n_cmp++; if (a_valid !== 1'b1 || a_busy !== 1'b1 || a_data !== ea[i] || a_last !== (i == 3)) begin
        n_bad++; $display("FAIL single_lsb beat%0d: v=%b busy=%b d=%h l=%b required 1/1/%h/%b",
                          i, a_valid, a_busy, a_data, a_last, ea[i], (i == 3)); end
      n_cmp++; if (b_valid !== 1'b1 || b_busy !== 1'b1 || b_data !== eb[i] || b_last !== (i == 3)) begin
        n_bad++; $display("FAIL single_msb beat%0d: v=%b busy=%b d=%h l=%b required 1/1/%h/%b",
                          i, b_valid, b_busy, b_data, b_last, eb[i], (i == 3)); end
    end
    step(); #1;
    n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_busy !== 1'b0 || a_rdreq !== 1'b0) begin
      n_bad++; $display("FAIL single_end: valid=%b/%b busy=%b rdreq=%b required 0", a_valid, b_valid, a_busy, a_rdreq); end
  endtask

  task automatic test_streaming();
    logic [31:0] w1, w2, wc;
    logic [7:0]  ea, eb;
    w1 = 32'hDDCCBBAA; w2 = 32'h44332211;
    step(); in_q = w1; in_empty = 1'b0; out_ready = 1'b1; #1;
    n_cmp++; if (a_rdreq !== 1'b1) begin n_bad++; $display("FAIL stream_start_pop: got %b required 1", a_rdreq); end
    for (int k = 0; k < 8; k++) begin
      step(); in_q = w2; in_empty = (k >= 4); #1;
      wc = (k < 4) ? w1 : w2;
      ea = wc[8*(k%4) +: 8];
      eb = wc[8*(3-(k%4)) +: 8];
      n_cmp++; if (a_valid !== 1'b1 || a_data !== ea || a_last !== ((k%4) == 3) || a_rdreq !== (k == 3)) begin
        n_bad++; $display("FAIL stream_lsb k%0d: v=%b d=%h l=%b rd=%b required 1/%h/%b/%b",
                          k, a_valid, a_data, a_last, a_rdreq, ea, ((k%4) == 3), (k == 3)); end
      n_cmp++; if (b_valid !== 1'b1 || b_data !== eb || b_rdreq !== (k == 3)) begin
        n_bad++; $display("FAIL stream_msb k%0d: v=%b d=%h rd=%b required 1/%h/%b", k, b_valid, b_data, b_rdreq, eb, (k == 3)); end
    end
    step(); #1;
    n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end: got %b required 0", a_valid); end
  endtask

  task automatic test_backpressure();
    step(); in_q = 32'hDDCCBBAA; in_empty = 1'b0; out_ready = 1'b1;
    step(); in_q = 32'h44332211; #1;
    n_cmp++; if (a_data !== 8'hAA || a_rdreq !== 1'b0) begin
      n_bad++; $display("FAIL bp_beat0: d=%h rd=%b required aa/0", a_data, a_rdreq); end
    step(); out_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); #1; end
      n_cmp++; if (a_valid !== 1'b1 || a_data !== 8'hBB || a_last !== 1'b0 || a_rdreq !== 1'b0) begin
        n_bad++; $display("FAIL bp_stall%0d: v=%b d=%h l=%b rd=%b required 1/bb/0/0", i, a_valid, a_data, a_last, a_rdreq); end
    end
    step(); out_ready = 1'b1; #1;
    n_cmp++; if (a_data !== 8'hBB || a_rdreq !== 1'b0) begin
      n_bad++; $display("FAIL bp_resume: d=%h rd=%b required bb/0", a_data, a_rdreq); end
    step(); #1;
    n_cmp++; if (a_data !== 8'hCC || a_last !== 1'b0) begin
      n_bad++; $display("FAIL bp_cc: d=%h l=%b required cc/0", a_data, a_last); end
    step(); #1;
    n_cmp++; if (a_data !== 8'hDD || a_last !== 1'b1 || a_rdreq !== 1'b1) begin
      n_bad++; $display("FAIL bp_dd: d=%h l=%b rd=%b required dd/1/1", a_data, a_last, a_rdreq); end
    step(); in_empty = 1'b1; #1;
    n_cmp++; if (a_valid !== 1'b1 || a_data !== 8'h11) begin
      n_bad++; $display("FAIL bp_next: v=%b d=%h required 1/11", a_valid, a_data); end
    drain();
  endtask

  task automatic test_ratio1();
    logic [7:0] w [3];
    w[0] = 8'h5A; w[1] = 8'hA5; w[2] = 8'h3C;
    step(); c_q = w[0]; c_empty = 1'b0; c_ready = 1'b1; #1;
    n_cmp++; if (c_rdreq !== 1'b1 || c_valid !== 1'b0) begin
      n_bad++; $display("FAIL r1_pop: rd=%b v=%b required 1/0", c_rdreq, c_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (k < 2) c_q = w[k+1]; else c_empty = 1'b1;
      #1;
      n_cmp++; if (c_valid !== 1'b1 || c_busy !== 1'b1 || c_data !== w[k] || c_last !== 1'b1 || c_rdreq !== (k < 2)) begin
        n_bad++; $display("FAIL r1_beat%0d: v=%b busy=%b d=%h l=%b rd=%b required 1/1/%h/1/%b",
                          k, c_valid, c_busy, c_data, c_last, c_rdreq, w[k], (k < 2)); end
    end
    step(); #1;
    n_cmp++; if (c_valid !== 1'b0 || c_last !== 1'b0) begin
      n_bad++; $display("FAIL r1_end: v=%b l=%b required 0/0", c_valid, c_last); end
  endtask

  task automatic test_reset_mid_word();
    step(); in_q = 32'hDDCCBBAA; in_empty = 1'b0; out_ready = 1'b1;
    step(); in_empty = 1'b1;
    step();
    step(); #1;
    n_cmp++; if (a_data !== 8'hCC) begin n_bad++; $display("FAIL mid_beat2: got %h required cc", a_data); end
    #1; in_q = 32'h44332211; in_empty = 1'b0; rst = 1'b1; #1;
    n_cmp++; if (a_valid !== 1'b0 || a_last !== 1'b0 || a_rdreq !== 1'b0) begin
      n_bad++; $display("FAIL mid_async: v=%b l=%b rd=%b required 0/0/0", a_valid, a_last, a_rdreq); end
    step(); #1;
    n_cmp++; if (a_valid !== 1'b0 || a_rdreq !== 1'b0) begin
      n_bad++; $display("FAIL mid_held: v=%b rd=%b required 0/0", a_valid, a_rdreq); end
    rst = 1'b0; #1;
    n_cmp++; if (a_rdreq !== 1'b1) begin n_bad++; $display("FAIL mid_repop: got %b required 1", a_rdreq); end
    step(); in_empty = 1'b1; #1;
    n_cmp++; if (a_valid !== 1'b1 || a_data !== 8'h11 || a_last !== 1'b0) begin
      n_bad++; $display("FAIL mid_beat0: v=%b d=%h l=%b required 1/11/0", a_valid, a_data, a_last); end
    drain();
  endtask

  task automatic test_random();
    logic [8:0]  exp_q [$];
    logic [8:0]  e;
    logic [31:0] head;
    int          n_pops, n_beats;
    n_pops = 0; n_beats = 0;
    head = $urandom;
    for (int c = 0; c < 420; c++) begin
      step();
      in_q      = head;
      in_empty  = (c >= 400) ? 1'b1 : ($urandom_range(0, 2) == 0);
      out_ready = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (a_rdreq) begin
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), head[8*i +: 8]});
        n_pops++;
        head = $urandom;
      end
      if (a_valid && out_ready) begin
        n_beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: beat %h with nothing expected", a_data);
        end else begin
          e = exp_q.pop_front();
          if ({a_last, a_data} !== e) begin
            n_bad++; $display("FAIL rand_beat%0d: last/data=%b/%h required %b/%h", n_beats, a_last, a_data, e[8], e[7:0]);
          end
        end
      end
    end
    n_cmp++;
    if (n_beats !== 4 * n_pops || exp_q.size() != 0 || n_pops == 0) begin
      n_bad++; $display("FAIL rand_count: beats=%0d pops=%0d left=%0d required beats=4*pops, left=0", n_beats, n_pops, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_ratio1();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
